// File: rtl/output_scheduler.sv
// Round-robin drain of NUM_CH channel FIFOs into one output register with a four-phase IRQ/ack handshake.
// Optional NOTIFY timeout with a sticky overrun flag is compiled in with OUTPUT_SCHED_TIMEOUT_EN.
module output_scheduler #(
  parameter int NUM_CH   = 4,
  parameter int CH_W     = 3,
  parameter int IRQ_HOLD = 36
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [NUM_CH-1:0]     ch_enable,
  input  logic [4*NUM_CH-1:0]   fifo_avail,
  input  logic [11*NUM_CH-1:0]  fifo_q,
  output logic [NUM_CH-1:0]     fifo_rdreq,
  output logic [10:0]           data_out,
  output logic [CH_W-1:0]       chan_out,
  output logic                  irq,
  input  logic                  host_ack,
  output logic                  busy,
  output logic                  overrun
);

  localparam int SLOTS = 1 << CH_W;

  typedef enum logic [2:0] {IDLE, READ, CAPTURE, NOTIFY, RELEASE} state_t;

  state_t           state, state_nxt;
  logic [CH_W-1:0]  rr_ptr;
  logic [CH_W-1:0]  sel;
  logic [CH_W-1:0]  pick;
  logic             found;
  logic             grant;
  logic             timeout;
  logic [SLOTS-1:0] eligible;
  logic [10:0]      q_arr [SLOTS];

  // Per-slot views padded to a power of two so CH_W-wide indices always fit.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < SLOTS; i++) begin
      q_arr[i] = '0;
      if (i < NUM_CH) begin
        eligible[i] = ch_enable[i] && (fifo_avail[4*i +: 4] != 4'd0);
        q_arr[i]    = fifo_q[11*i +: 11];
      end
    end
  end

  always_comb begin
    logic [CH_W:0] idx;
    found = 1'b0;
    pick  = '0;
    idx   = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      idx = {1'b0, rr_ptr} + (CH_W+1)'(k);
      if (idx >= (CH_W+1)'(NUM_CH))
        idx = idx - (CH_W+1)'(NUM_CH);
      if (!found && eligible[idx[CH_W-1:0]]) begin
        found = 1'b1;
        pick  = idx[CH_W-1:0];
      end
    end
  end

  // A high ack in IDLE belongs to a previous handshake, so it blocks the grant.
  assign grant = (state == IDLE) && !host_ack && found;
  assign busy  = (state != IDLE);

`ifdef OUTPUT_SCHED_TIMEOUT_EN
  logic [7:0] hold_cnt;

  assign timeout = (hold_cnt + 8'd1 == 8'(IRQ_HOLD));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hold_cnt <= '0;
      overrun  <= 1'b0;
    end else begin
      if (state == CAPTURE)
        hold_cnt <= '0;
      else if (state == NOTIFY)
        hold_cnt <= hold_cnt + 8'd1;
      if (state == NOTIFY && !host_ack && timeout)
        overrun <= 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
  assign overrun = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (grant) state_nxt = READ;
      READ:     state_nxt = CAPTURE;
      CAPTURE:  state_nxt = NOTIFY;
      NOTIFY: begin
        if (host_ack)
          state_nxt = RELEASE;
        else if (timeout)
          state_nxt = IDLE;
      end
      RELEASE:  if (!host_ack) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr     <= '0;
      sel        <= '0;
      fifo_rdreq <= '0;
      data_out   <= '0;
      chan_out   <= '0;
      irq        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant) begin
            sel        <= pick;
            fifo_rdreq <= NUM_CH'(1) << pick;
          end
        end
        READ:
          fifo_rdreq <= '0;
        CAPTURE: begin
          data_out <= q_arr[sel];
          chan_out <= sel;
          irq      <= 1'b1;
          rr_ptr   <= (sel == CH_W'(NUM_CH-1)) ? '0 : sel + 1'b1;
        end
        NOTIFY:
          if (host_ack || timeout)
            irq <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_output_scheduler.sv
// Directed bench for output_scheduler with a small behavioural FIFO per channel.
// Builds with or without OUTPUT_SCHED_TIMEOUT_EN.
module tb_output_scheduler;

  localparam int NUM_CH = 4;
  localparam int CH_W   = 3;

  logic                 clock = 1'b0;
  logic                 reset_n;
  logic [NUM_CH-1:0]    ch_enable;
  logic [4*NUM_CH-1:0]  fifo_avail;
  logic [11*NUM_CH-1:0] fifo_q;
  logic [NUM_CH-1:0]    fifo_rdreq;
  logic [10:0]          data_out;
  logic [CH_W-1:0]      chan_out;
  logic                 irq;
  logic                 host_ack;
  logic                 busy;
  logic                 overrun;

  logic [3:0]  avail     [NUM_CH];
  logic [10:0] q         [NUM_CH];
  logic [10:0] next_word [NUM_CH];

  int   checks = 0;
  int   failures = 0;
  int   rdreq_cycles = 0;
  logic multihot_seen = 1'b0;
  logic underflow_seen = 1'b0;

  output_scheduler #(.NUM_CH(NUM_CH), .CH_W(CH_W), .IRQ_HOLD(36)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .ch_enable  (ch_enable),
    .fifo_avail (fifo_avail),
    .fifo_q     (fifo_q),
    .fifo_rdreq (fifo_rdreq),
    .data_out   (data_out),
    .chan_out   (chan_out),
    .irq        (irq),
    .host_ack   (host_ack),
    .busy       (busy),
    .overrun    (overrun)
  );

  always #5 clock = ~clock;

  always_comb begin
    fifo_avail = '0;
    fifo_q     = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      fifo_avail[4*i +: 4] = avail[i];
      fifo_q[11*i +: 11]   = q[i];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to the next falling edge and let the FIFO model react to a pending read.
  task automatic tick();
    @(negedge clock);
    if (!$onehot0(fifo_rdreq)) multihot_seen = 1'b1;
    if (fifo_rdreq != '0) rdreq_cycles++;
    for (int i = 0; i < NUM_CH; i++) begin
      if (fifo_rdreq[i]) begin
        if (avail[i] == 4'd0) underflow_seen = 1'b1;
        else avail[i] = avail[i] - 4'd1;
        q[i] = next_word[i];
        next_word[i] = next_word[i] + 11'd1;
      end
    end
  endtask

  task automatic do_reset();
    reset_n  = 1'b0;
    host_ack = 1'b0;
    #1;
    repeat (2) tick();
    check("rst_rdreq", fifo_rdreq, 0);
    check("rst_irq", irq, 0);
    check("rst_busy", busy, 0);
    check("rst_data", data_out, 0);
    check("rst_chan", chan_out, 0);
    check("rst_overrun", overrun, 0);
    reset_n = 1'b1;
  endtask

  task automatic clear_fifos();
    for (int i = 0; i < NUM_CH; i++) begin
      avail[i] = 4'd0;
      q[i] = 11'd0;
      next_word[i] = 11'd0;
    end
  endtask

  task automatic wait_irq(input string tag);
    int n = 0;
    while (!irq && n < 40) begin
      tick();
      n++;
    end
    check({tag, "_irq"}, irq, 1);
  endtask

  task automatic serve(input string tag, input int ch, input logic [10:0] dat);
    int n = 0;
    wait_irq(tag);
    check({tag, "_chan"}, chan_out, ch);
    check({tag, "_data"}, data_out, dat);
    host_ack = 1'b1;
    while (irq && n < 40) begin
      tick();
      n++;
    end
    check({tag, "_irq_drop"}, irq, 0);
    host_ack = 1'b0;
    tick();
  endtask

  initial begin
    clear_fifos();
    ch_enable = '1;
    do_reset();

    // Single sample on channel 0 with exact latency
    next_word[0] = 11'h5A3;
    avail[0] = 4'd1;
    rdreq_cycles = 0;
    tick();
    check("t1_rdreq_grant", fifo_rdreq, 4'b0001);
    check("t1_irq_e0", irq, 0);
    tick();
    check("t1_rdreq_drop", fifo_rdreq, 0);
    check("t1_irq_e1", irq, 0);
    tick();
    check("t1_irq_rise", irq, 1);
    check("t1_data", data_out, 11'h5A3);
    check("t1_chan", chan_out, 0);
    tick();
    tick();
    check("t1_irq_hold", irq, 1);
    host_ack = 1'b1;
    tick();
    check("t1_irq_fall", irq, 0);
    host_ack = 1'b0;
    tick();
    tick();
    check("t1_busy_idle", busy, 0);
    check("t1_rdreq_cycles", rdreq_cycles, 1);
    check("t1_data_hold", data_out, 11'h5A3);

    // Fair rotation over all four channels
    clear_fifos();
    do_reset();
    for (int i = 0; i < NUM_CH; i++) begin
      next_word[i] = 11'(11'h100 * i);
      avail[i] = 4'd3;
    end
    for (int k = 0; k < 8; k++)
      serve("t2", k % 4, 11'(11'h100 * (k % 4) + k / 4));
    check("t2_multihot", multihot_seen, 0);
    for (int i = 0; i < NUM_CH; i++)
      check("t2_avail_left", avail[i], 1);

    // Masked channels
    clear_fifos();
    ch_enable = '0;
    do_reset();
    ch_enable = 4'b1010;
    next_word[1] = 11'h010;
    next_word[3] = 11'h030;
    for (int i = 0; i < NUM_CH; i++) avail[i] = 4'd2;
    serve("t3a", 1, 11'h010);
    serve("t3b", 3, 11'h030);
    serve("t3c", 1, 11'h011);
    serve("t3d", 3, 11'h031);
    repeat (3) tick();
    check("t3_busy", busy, 0);
    check("t3_avail1", avail[1], 0);
    check("t3_avail3", avail[3], 0);
    check("t3_avail0", avail[0], 2);

    // Stale ack blocks the grant
    clear_fifos();
    do_reset();
    ch_enable = '1;
    host_ack = 1'b1;
    tick();
    next_word[2] = 11'h2AB;
    avail[2] = 4'd1;
    rdreq_cycles = 0;
    repeat (5) tick();
    check("t4_no_rdreq", rdreq_cycles, 0);
    check("t4_busy", busy, 0);
    host_ack = 1'b0;
    tick();
    check("t4_grant", fifo_rdreq, 4'b0100);
    serve("t4", 2, 11'h2AB);

    // Reset during NOTIFY; rr_ptr is 3 beforehand
    next_word[1] = 11'h1C1;
    avail[1] = 4'd1;
    wait_irq("t5_pre");
    check("t5_pre_chan", chan_out, 1);
    reset_n = 1'b0;
    #1;
    check("t5_async_irq", irq, 0);
    check("t5_async_busy", busy, 0);
    check("t5_async_data", data_out, 0);
    tick();
    reset_n = 1'b1;
    next_word[0] = 11'h111;
    next_word[3] = 11'h333;
    avail[0] = 4'd1;
    avail[3] = 4'd1;
    serve("t5a", 0, 11'h111);
    serve("t5b", 3, 11'h333);

`ifdef OUTPUT_SCHED_TIMEOUT_EN
    begin
      int n = 0;
      clear_fifos();
      do_reset();
      next_word[2] = 11'h0CC;
      avail[2] = 4'd1;
      wait_irq("t6");
      while (irq && n < 100) begin
        n++;
        tick();
      end
      check("t6_irq_cycles", n, 36);
      check("t6_overrun", overrun, 1);
      check("t6_busy", busy, 0);
      next_word[1] = 11'h0DD;
      avail[1] = 4'd1;
      serve("t6_next", 1, 11'h0DD);
      check("t6_overrun_sticky", overrun, 1);
    end
`else
    check("overrun_tied", overrun, 0);
`endif

    check("underflow", underflow_seen, 0);
    check("multihot_all", multihot_seen, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/output_scheduler.md
Name: output_scheduler

Overview:
- Round-robin scheduler that drains NUM_CH per-channel sample FIFOs (11-bit ADC words) into a single host-facing output register.
- Raises IRQ per sample and holds it under a four-phase ack handshake with the host interface.
- Sits between the per-channel acquisition FIFOs and the host bus/interrupt logic.
- Replaces per-channel fixed-timing drain logic with shared, fair access to the single output path.

Parameters:
- NUM_CH, 4, number of channel FIFOs; 2..8.
- CH_W, 3, width of the channel index; must satisfy 2**CH_W >= NUM_CH.
- IRQ_HOLD, 36, NOTIFY-state timeout in clock cycles; used only with OUTPUT_SCHED_TIMEOUT_EN.

Ports:
- clock  in  1  single system clock; all logic on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- ch_enable  in  NUM_CH  per-channel enable mask; bit i=0 excludes channel i from arbitration.
- fifo_avail  in  4*NUM_CH  per-channel FIFO fill count; channel i uses bits [4i+3:4i].
- fifo_q  in  11*NUM_CH  per-channel FIFO read data, valid the cycle after rdreq.
- fifo_rdreq  out  NUM_CH  one-hot read request, single-cycle pulse.
- data_out  out  11  captured sample.
- chan_out  out  CH_W  channel index of data_out.
- irq  out  1  sample-ready interrupt.
- host_ack  in  1  host acknowledge; four-phase.
- busy  out  1  high in any state other than IDLE.
- overrun  out  1  sticky flag: IRQ timed out unacknowledged (feature only).

Behaviour:
- Reset (reset_n low, asynchronous):
  - state=IDLE, rr_ptr=0, fifo_rdreq=0, data_out=0, chan_out=0, irq=0, busy=0, overrun=0.
  - Asserting reset mid-transaction aborts it immediately. A FIFO word already popped is lost; this is accepted.
- States: IDLE, READ, CAPTURE, NOTIFY, RELEASE.
- IDLE:
  - A channel is eligible when ch_enable[i]=1 and fifo_avail[i]!=0.
  - Grant happens only when host_ack=0 and at least one channel is eligible.
  - The search starts at rr_ptr and increments modulo NUM_CH; the first eligible channel wins.
  - On grant: latch sel; set fifo_rdreq[sel]<=1; go to READ.
- READ (1 cycle): fifo_rdreq<=0; go to CAPTURE.
- CAPTURE (1 cycle):
  - data_out<=fifo_q[sel], chan_out<=sel, irq<=1.
  - rr_ptr<=(sel==NUM_CH-1)?0:sel+1.
  - Go to NOTIFY.
- NOTIFY: hold irq=1 until host_ack=1, then irq<=0 and go to RELEASE.
- RELEASE: wait for host_ack=0, then go to IDLE.
- Latency:
  - Grant edge E.
  - rdreq high during cycle E..E+1.
  - data_out and irq valid after edge E+2.
  - Minimum 5 cycles per sample when ack is immediate: IDLE, READ, CAPTURE, NOTIFY, RELEASE.
- Boundary conditions:
  - data_out and chan_out hold their values until the next CAPTURE; they are never cleared except by reset.
  - fifo_rdreq is never asserted when fifo_avail[sel]==0 at the grant edge, so there is no FIFO underflow.
  - fifo_rdreq is never multi-hot.
  - Changes to ch_enable or fifo_avail after grant do not affect the current transaction.
  - Disabling channel sel mid-transaction still completes the delivery.
  - host_ack already high while in IDLE blocks the grant; this avoids a false ack.
  - host_ack pulses while in READ or CAPTURE are ignored; only the ack level in NOTIFY counts.
  - All channels disabled: the block stays in IDLE with busy=0.

Optional Feature:
- Macro: OUTPUT_SCHED_TIMEOUT_EN.
- Defined:
  - An 8-bit counter clears on CAPTURE and increments every cycle in NOTIFY.
  - If the counter reaches IRQ_HOLD with host_ack still 0: irq<=0, overrun<=1 (sticky until reset), go directly to IDLE.
  - An ack in the same cycle the timeout is reached takes priority: normal path, no overrun.
- Not defined:
  - NOTIFY waits indefinitely.
  - overrun is tied to 0 and no counter is instantiated.

Test Plan:
- Reset, then ch0 fifo_avail=1 with fifo_q[0]=11'h5A3; ack 2 cycles after irq:
  - fifo_rdreq=4'b0001 for exactly 1 cycle.
  - irq rises 3 edges after avail is sampled; data_out=11'h5A3, chan_out=0.
  - irq falls the edge after ack.
- All 4 channels avail=3, immediate ack, 8 transactions:
  - chan_out sequence is 0,1,2,3,0,1,2,3.
  - No fifo_rdreq is multi-hot.
- ch_enable=4'b1010, all avail=2:
  - Only channels 1 and 3 are served, alternating 1,3,1,3.
  - busy=0 once their avail reaches 0.
- host_ack held high before any data arrives; ch2 avail=1:
  - No grant and fifo_rdreq stays 0.
  - Drop ack → grant to channel 2 on the next edge.
- reset_n pulsed low during NOTIFY:
  - irq, busy and data_out go to 0 asynchronously.
  - After release, arbitration restarts at channel 0.
- With OUTPUT_SCHED_TIMEOUT_EN, IRQ_HOLD=36, no ack:
  - irq high for exactly 36 cycles, then overrun=1.
  - The next available sample is still delivered.
